coeff_bank_server: RTL and testbench
====================================

// Module: coeff_bank_server
// PURPOSE
//  Coefficient-memory responder for the 8-channel FIR filter bank (profir).
//  Accepts 8 x NTAPS signed CW-bit coefficients over a valid/ready load stream,
//  packs them in tap pairs and serves all 8 filters in parallel from coeffaddress.
//  Sits between the host/config loader and the filter bank's coefficient inputs.
// PARAMETERS
//  CW     18   coefficient width (signed); output word = 2*CW = 36 bits
//  NTAPS  128  taps per filter (even); words per bank = NTAPS/2 = 64; AW = 6
// PORTS
//  clock         in   1      rising-edge clock
//  reset         in   1      synchronous, active-high
//  cload_start   in   1      1-cycle pulse: begin (or restart) full coefficient load
//  cdata         in   18     signed coefficient, stream order filter 0..7, tap 0..NTAPS-1
//  cdata_valid   in   1      cdata valid this cycle
//  cdata_ready   out  1      block accepts cdata this cycle (transfer = valid & ready)
//  coeff_valid   out  1      high once all 8*NTAPS coefficients loaded
//  coeffaddress  in   6      tap-pair word index requested by filter bank
//  coeff0..7     out  36 ea  bank f word: [17:0] = tap 2*addr, [35:18] = tap 2*addr+1
// BEHAVIOUR
//  Reset: state EMPTY; cdata_ready=0, coeff_valid=0, coeff0..7=0, counters=0,
//   even-tap holding reg=0. Memory contents not cleared (undefined until loaded).
//  Storage: 8 banks x 64 words x 36 bits; one write port shared, 8 read ports.
//  FSM: EMPTY, LOAD_EVEN, LOAD_ODD, READY.
//   EMPTY     : cdata_ready=0; cload_start -> LOAD_EVEN, tap_cnt=0, filt_cnt=0.
//   LOAD_EVEN : cdata_ready=1; on transfer latch cdata into hold reg -> LOAD_ODD.
//   LOAD_ODD  : cdata_ready=1; on transfer write {cdata, hold} to
//               bank[filt_cnt][tap_cnt>>1]; tap_cnt+=2; if tap_cnt wraps NTAPS,
//               tap_cnt=0, filt_cnt+=1; after filter 7 last pair -> READY,
//               else -> LOAD_EVEN.
//   READY     : cdata_ready=0, coeff_valid=1; extra cdata ignored;
//               cload_start -> LOAD_EVEN (coeff_valid drops next cycle).
//  cload_start in LOAD_EVEN/LOAD_ODD: abort, counters and hold reg cleared,
//   restart at filter 0 tap 0 in LOAD_EVEN; a transfer in the same cycle is dropped.
//  coeff_valid is 0 in EMPTY/LOAD_*; registered, rises the cycle after final write.
//  Read: registered, latency 1: coeffaddress sampled at edge N, coeffX valid
//   after edge N (usable by filter at edge N+1). Reads always permitted; during
//   LOAD_* data may be partially updated, consumers must gate on coeff_valid.
//  Write/read same word same edge: read returns old contents (read-before-write).
//  Bit packing: no arithmetic; cdata stored verbatim, sign preserved per half.
//  Load throughput: 1 coefficient/cycle when cdata_valid held high; full load
//   = 8*NTAPS = 1024 transfers; valid may deassert any cycle (stall, no loss).
//  Reset mid-load or mid-read: immediate return to EMPTY next edge, outputs 0.
// TESTING
//  T1 reset held 3 cycles -> cdata_ready=0, coeff_valid=0, coeff0..7=0.
//  T2 start + 1024 back-to-back coeffs value = f*256+tap -> coeff_valid high
//     after 1024th transfer; addr=5 -> coeff3 = {18'd779, 18'd778} one cycle later.
//  T3 load with cdata_valid toggling 1/0 and negative coeffs (-1, -131072) ->
//     coeff0 addr 0 = 36'hFFFFE0000-style pair exact, no dropped/duplicate taps.
//  T4 cload_start after 300 transfers then full 1024 load -> contents match second
//     stream only; coeff_valid low until its 1024th transfer.
//  T5 in READY, sweep coeffaddress 0..63 each cycle -> each bank output matches
//     word of address from previous cycle; extra cdata_valid ignored.
//  T6 reset asserted during LOAD_ODD -> EMPTY, coeff_valid=0; reload succeeds.

Source files
------------

// File: rtl/coeff_bank_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | coeff_bank_if                                                              |
// | Coefficient load stream plus 8-bank parallel read bus for the filter bank. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface coeff_bank_if #(
  parameter int CW = 18,
  parameter int AW = 6
);
  logic                 cload_start;
  logic signed [CW-1:0] cdata;
  logic                 cdata_valid;
  logic                 cdata_ready;
  logic                 coeff_valid;
  logic [AW-1:0]        coeffaddress;
  logic [2*CW-1:0]      coeff0;
  logic [2*CW-1:0]      coeff1;
  logic [2*CW-1:0]      coeff2;
  logic [2*CW-1:0]      coeff3;
  logic [2*CW-1:0]      coeff4;
  logic [2*CW-1:0]      coeff5;
  logic [2*CW-1:0]      coeff6;
  logic [2*CW-1:0]      coeff7;

  modport master (
    output cload_start, cdata, cdata_valid, coeffaddress,
    input  cdata_ready, coeff_valid,
    input  coeff0, coeff1, coeff2, coeff3, coeff4, coeff5, coeff6, coeff7
  );

  modport slave (
    input  cload_start, cdata, cdata_valid, coeffaddress,
    output cdata_ready, coeff_valid,
    output coeff0, coeff1, coeff2, coeff3, coeff4, coeff5, coeff6, coeff7
  );
endinterface
`default_nettype wire

// File: rtl/coeff_bank_server.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | coeff_bank_server                                                          |
// | Loads 8 x NTAPS coefficients as tap pairs and serves 8 filters in parallel.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module coeff_bank_server #(
  parameter int CW    = 18,
  parameter int NTAPS = 128
) (
  input  logic         clock,
  input  logic         reset,
  coeff_bank_if.slave  bus
);

  localparam int c_NBANK = 8;
  localparam int c_WORDS = NTAPS / 2;
  localparam int c_TW    = $clog2(NTAPS);
  localparam logic [c_TW-1:0] c_LAST_TAP = c_TW'(NTAPS - 2);

  localparam logic [1:0] c_EMPTY     = 2'd0;
  localparam logic [1:0] c_LOAD_EVEN = 2'd1;
  localparam logic [1:0] c_LOAD_ODD  = 2'd2;
  localparam logic [1:0] c_READY     = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic            w_cdata_ready;
  logic            w_xfer;
  logic            w_wr_en;
  logic            w_last_pair;
  logic [c_TW-1:0] r_tap_cnt;
  logic [2:0]      r_filt_cnt;
  logic [CW-1:0]   r_hold;
  logic            r_coeff_valid;
  logic [2*CW-1:0] w_rd_data [c_NBANK];

  assign w_xfer      = bus.cdata_valid & w_cdata_ready;
  assign w_last_pair = (r_filt_cnt == 3'd7) && (r_tap_cnt == c_LAST_TAP);
  // A transfer coinciding with cload_start is dropped by the restart.
  assign w_wr_en     = (r_state == c_LOAD_ODD) & w_xfer & ~bus.cload_start;

  always_ff @(posedge clock) begin
    if (reset) r_state <= c_EMPTY;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.cload_start) begin
      w_next_state = c_LOAD_EVEN;
    end else begin
      case (r_state)
        c_LOAD_EVEN: if (w_xfer) w_next_state = c_LOAD_ODD;
        c_LOAD_ODD:  if (w_xfer) w_next_state = w_last_pair ? c_READY : c_LOAD_EVEN;
        default:     w_next_state = r_state;
      endcase
    end
  end

  always_comb begin
    w_cdata_ready = (r_state == c_LOAD_EVEN) || (r_state == c_LOAD_ODD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tap_cnt     <= '0;
      r_filt_cnt    <= '0;
      r_hold        <= '0;
      r_coeff_valid <= 1'b0;
    end else begin
      r_coeff_valid <= (w_next_state == c_READY);
      if (bus.cload_start) begin
        r_tap_cnt  <= '0;
        r_filt_cnt <= '0;
        r_hold     <= '0;
      end else if ((r_state == c_LOAD_EVEN) && w_xfer) begin
        r_hold <= bus.cdata;
      end else if (w_wr_en) begin
        if (r_tap_cnt == c_LAST_TAP) begin
          r_tap_cnt  <= '0;
          r_filt_cnt <= r_filt_cnt + 3'd1;
        end else begin
          r_tap_cnt  <= r_tap_cnt + c_TW'(2);
        end
      end
    end
  end

  for (genvar b = 0; b < c_NBANK; b++) begin : g_bank
    logic [2*CW-1:0] r_mem [c_WORDS];
    logic [2*CW-1:0] r_rd;

    always_ff @(posedge clock) begin
      if (w_wr_en && (r_filt_cnt == 3'(b)))
        r_mem[r_tap_cnt[c_TW-1:1]] <= {bus.cdata, r_hold};
    end

    // Separate read register gives read-before-write on a same-word collision.
    always_ff @(posedge clock) begin
      if (reset) r_rd <= '0;
      else       r_rd <= r_mem[bus.coeffaddress];
    end

    assign w_rd_data[b] = r_rd;
  end

  assign bus.cdata_ready = w_cdata_ready;
  assign bus.coeff_valid = r_coeff_valid;
  assign bus.coeff0      = w_rd_data[0];
  assign bus.coeff1      = w_rd_data[1];
  assign bus.coeff2      = w_rd_data[2];
  assign bus.coeff3      = w_rd_data[3];
  assign bus.coeff4      = w_rd_data[4];
  assign bus.coeff5      = w_rd_data[5];
  assign bus.coeff6      = w_rd_data[6];
  assign bus.coeff7      = w_rd_data[7];

endmodule
`default_nettype wire

// File: tb/tb_coeff_bank_server.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for coeff_bank_server: directed loads, a reference coefficient image,
// and a read scoreboard drained by a monitor one cycle after each request.
module tb_coeff_bank_server;

  typedef struct packed {
    logic [7:0][35:0] w;
    logic [5:0]       addr;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  coeff_bank_if #(.CW(18), .AW(6)) bus ();

  coeff_bank_server #(.CW(18), .NTAPS(128)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        sb_q[$];
  logic [35:0] mdl [8][64];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        rd_req   = 1'b0;
  logic        rd_req_d = 1'b0;

  always @(posedge clock) rd_req_d <= rd_req;

  function automatic logic [35:0] got_word(input int b);
    case (b)
      0: return bus.coeff0;
      1: return bus.coeff1;
      2: return bus.coeff2;
      3: return bus.coeff3;
      4: return bus.coeff4;
      5: return bus.coeff5;
      6: return bus.coeff6;
      default: return bus.coeff7;
    endcase
  endfunction

  // Coefficient stream generators; i is the stream index (filter = i/128, tap = i%128).
  function automatic logic [17:0] gen(input int kind, input int i);
    int f;
    int t;
    f = i / 128;
    t = i % 128;
    case (kind)
      0: return 18'(f * 256 + t);
      1: begin
        if (t == 0)      return 18'h20000;
        else if (t == 1) return 18'h3FFFF;
        else             return 18'(-(i + 1));
      end
      2: return 18'h15555 ^ 18'(i);
      3: return 18'(18'h2A000 + i * 7);
      default: return 18'(i * 37) ^ 18'h00F0F;
    endcase
  endfunction

  always @(negedge clock) begin
    if (rd_req_d) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got read with empty queue, expected queued entry");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        for (int b = 0; b < 8; b++) begin
          n_cmp++;
          if (got_word(b) !== e.w[b]) begin
            n_err++;
            $display("FAIL rd_bank%0d_addr%0d: got %h expected %h", b, e.addr, got_word(b), e.w[b]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic read_addr(input int a);
    exp_t e;
    bus.coeffaddress = 6'(a);
    rd_req = 1'b1;
    for (int b = 0; b < 8; b++) e.w[b] = mdl[b][a];
    e.addr = 6'(a);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic load_run(input int kind, input int count, input bit gaps, input bit do_start);
    logic [17:0] v;
    logic [17:0] even_v;
    int i;
    i = 0;
    even_v = '0;
    if (do_start) begin
      bus.cload_start = 1'b1;
      bus.cdata_valid = 1'b0;
      @(posedge clock);
      #1;
      bus.cload_start = 1'b0;
      check("cv_low_after_start", 64'(bus.coeff_valid), 64'd0);
    end
    while (i < count) begin
      v = gen(kind, i);
      bus.cdata = v;
      bus.cdata_valid = 1'b1;
      @(negedge clock);
      if (!bus.cdata_ready) begin
        n_cmp++;
        n_err++;
        $display("FAIL ready_timeout: got cdata_ready 0 at transfer %0d, expected 1", i);
        bus.cdata_valid = 1'b0;
        return;
      end
      if (count == 1024 && i == count - 1)
        check("cv_low_before_last", 64'(bus.coeff_valid), 64'd0);
      @(posedge clock);
      #1;
      if (i % 2 == 0) even_v = v;
      else            mdl[i / 128][(i % 128) / 2] = {v, even_v};
      i++;
      if (gaps) begin
        bus.cdata_valid = 1'b0;
        bus.cdata = 18'h1F1F1;
        @(posedge clock);
        #1;
      end
    end
    bus.cdata_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cload_start  = 1'b0;
    bus.cdata        = '0;
    bus.cdata_valid  = 1'b0;
    bus.coeffaddress = '0;
    reset = 1'b1;

    // T1: reset state
    idle(3);
    check("rst_ready", 64'(bus.cdata_ready), 64'd0);
    check("rst_cv", 64'(bus.coeff_valid), 64'd0);
    for (int b = 0; b < 8; b++) check($sformatf("rst_coeff%0d", b), 64'(got_word(b)), 64'd0);
    reset = 1'b0;
    bus.cdata_valid = 1'b1;
    idle(2);
    bus.cdata_valid = 1'b0;
    check("empty_ready", 64'(bus.cdata_ready), 64'd0);

    // T2: back-to-back load of f*256+tap
    load_run(0, 1024, 1'b0, 1'b1);
    check("t2_cv_high", 64'(bus.coeff_valid), 64'd1);
    check("t2_ready_low", 64'(bus.cdata_ready), 64'd0);
    read_addr(5);
    check("t2_coeff3_a5", 64'(bus.coeff3), 64'({18'd779, 18'd778}));
    read_addr(63);
    check("t2_coeff7_a63", 64'(bus.coeff7), 64'({18'd1919, 18'd1918}));
    read_addr(0);

    // T3: stalled stream with negative coefficients
    load_run(1, 1024, 1'b1, 1'b1);
    check("t3_cv_high", 64'(bus.coeff_valid), 64'd1);
    read_addr(0);
    check("t3_coeff0_a0", 64'(bus.coeff0), 64'h0_0000_000F_FFFE_0000);
    read_addr(1);
    read_addr(40);

    // T4: abort after 300 transfers (with a same-cycle transfer dropped), then full reload
    load_run(2, 300, 1'b0, 1'b1);
    bus.cdata = 18'h3ABCD;
    bus.cdata_valid = 1'b1;
    bus.cload_start = 1'b1;
    @(posedge clock);
    #1;
    bus.cload_start = 1'b0;
    bus.cdata_valid = 1'b0;
    check("t4_cv_low_abort", 64'(bus.coeff_valid), 64'd0);
    load_run(3, 1024, 1'b0, 1'b0);
    check("t4_cv_high", 64'(bus.coeff_valid), 64'd1);
    read_addr(0);
    check("t4_coeff0_a0", 64'(bus.coeff0), 64'({18'h2A007, 18'h2A000}));
    read_addr(2);
    read_addr(33);

    // T5: address sweep in READY with stray cdata_valid
    bus.cdata = 18'h12345;
    bus.cdata_valid = 1'b1;
    for (int a = 0; a < 64; a++) read_addr(a);
    bus.cdata_valid = 1'b0;
    check("t5_cv_high", 64'(bus.coeff_valid), 64'd1);
    check("t5_ready_low", 64'(bus.cdata_ready), 64'd0);
    read_addr(7);

    // T6: reset during LOAD_ODD, then reload
    load_run(4, 3, 1'b0, 1'b1);
    check("t6_ready_in_load", 64'(bus.cdata_ready), 64'd1);
    reset = 1'b1;
    idle(1);
    check("t6_rst_ready", 64'(bus.cdata_ready), 64'd0);
    check("t6_rst_cv", 64'(bus.coeff_valid), 64'd0);
    check("t6_rst_coeff0", 64'(bus.coeff0), 64'd0);
    reset = 1'b0;
    idle(1);
    check("t6_empty_ready", 64'(bus.cdata_ready), 64'd0);
    load_run(4, 1024, 1'b0, 1'b1);
    check("t6_cv_high", 64'(bus.coeff_valid), 64'd1);
    read_addr(0);
    read_addr(17);
    read_addr(63);

    idle(3);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
